// File: rtl/z_tile_store_scheduler_pkg.sv
// Shared types for the Z-tile store scheduler: tile parameters, the streamer
// control word, FSM state encoding and the beat-count helper.
package z_tile_store_scheduler_pkg;

  localparam int unsigned Z_CNT_W = 16;

  typedef struct packed {
    logic [31:0]        base_address;
    logic [31:0]        row_stride;   // bytes between consecutive Z rows
    logic [Z_CNT_W-1:0] x_rows;
    logic [Z_CNT_W-1:0] y_columns;
    logic               col_major;    // 1: rows are the inner loop
  } z_tile_param_t;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
    logic [31:0] d3_stride;
    logic [1:0]  dim_enable_1h;
  } hci_streamer_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } z_state_e;

  // Number of bus beats needed to move `cols` elements of data_size bits.
  function automatic logic [31:0] z_blk_len(input logic [31:0] cols,
                                            input int unsigned data_size,
                                            input int unsigned bw);
    logic [31:0] bits;
    bits = cols * data_size;
    return (bits + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/z_tile_store_scheduler_if.sv
// Store-request channel between the scheduler and the Z sink streamer.
// Handshake: a transfer happens on a rising clock edge where req_valid and
// req_ready are both 1. Once req_valid is raised, the master keeps req_valid
// and ctrl unchanged until that transfer; req_valid never depends on
// req_ready, while req_ready may depend on req_valid.
interface z_tile_store_scheduler_if;
  import z_tile_store_scheduler_pkg::*;

  hci_streamer_ctrl_t ctrl;
  logic               req_valid;
  logic               req_ready;

  modport master (output ctrl, output req_valid, input req_ready);
  modport slave  (input ctrl, input req_valid, output req_ready);

endinterface

// File: rtl/z_tile_store_scheduler_addr_gen.sv
// Address and length generator for one Z block: start address of the block
// at (row, col_blk) and its beat count, including the partial last block.
module z_tile_store_scheduler_addr_gen
  import z_tile_store_scheduler_pkg::*;
#(
  parameter int unsigned BW           = 128,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned Y_BLOCK_SIZE = 4,
  parameter int unsigned CNT_W        = Z_CNT_W
) (
  input  logic [CNT_W-1:0] row,
  input  logic [CNT_W-1:0] col_blk,
  input  logic [31:0]      base_address,
  input  logic [31:0]      row_stride,
  input  logic [CNT_W-1:0] y_columns,
  output logic [31:0]      base_addr,
  output logic [31:0]      tot_len
);

  localparam int unsigned    Y_SH      = $clog2(Y_BLOCK_SIZE);
  localparam logic [31:0]    BLK_BYTES = 32'(Y_BLOCK_SIZE * (DATA_SIZE / 8));
  localparam logic [CNT_W:0] Y_BLK     = (CNT_W+1)'(Y_BLOCK_SIZE);

  logic [CNT_W:0] col_first;
  logic [CNT_W:0] col_left;
  logic [CNT_W:0] cols;

  // Column count of this block (clipped for the tail) and its address.
  always_comb begin
    col_first = {1'b0, col_blk} << Y_SH;
    // col_blk < nblk, so this subtraction cannot underflow
    col_left  = {1'b0, y_columns} - col_first;
    cols      = (col_left > Y_BLK) ? Y_BLK : col_left;
    base_addr = base_address + 32'(row) * row_stride + 32'(col_blk) * BLK_BYTES;
    tot_len   = z_blk_len(32'(cols), DATA_SIZE, BW);
  end

endmodule

// File: rtl/z_tile_store_scheduler.sv
// Z-tile store scheduler: walks X rows by Y column blocks in row- or
// column-major order and issues one streamer store request per block,
// gated by credits that the compute engine grants with proceed pulses.
module z_tile_store_scheduler
  import z_tile_store_scheduler_pkg::*;
#(
  parameter int unsigned BW           = 128,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned Y_BLOCK_SIZE = 4,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CNT_W        = Z_CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  z_tile_param_t            params_i,
  input  logic                     proceed_i,
  z_tile_store_scheduler_if.master store,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         row_o,
  output logic [CNT_W-1:0]         col_blk_o,
  output logic                     overflow_o,
  output z_state_e                 state_o
);

  localparam int unsigned     Y_SH   = $clog2(Y_BLOCK_SIZE);
  localparam int unsigned     CR_W   = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDIT_DEPTH);
  localparam logic [CR_W-1:0] CR_ONE = CR_W'(1);
  localparam logic [CNT_W:0]  BLK_M1 = (CNT_W+1)'(Y_BLOCK_SIZE - 1);
  localparam logic [CNT_W:0]  ONE_W  = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  z_state_e         state_q, state_d;
  z_tile_param_t    params_q, params_d;
  logic [CNT_W:0]   nblk_q, nblk_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [CR_W-1:0]  cr_q, cr_d;
  logic [31:0]      base_q, base_d, len_q, len_d;
  logic             cfg_q, cfg_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      gen_base, gen_len;
  logic             accept, row_wrap, col_wrap, last_blk, empty_tile;

  assign accept     = valid_q & store.req_ready;
  assign row_wrap   = ({1'b0, row_q} == ({1'b0, params_q.x_rows} - ONE_W));
  assign col_wrap   = ({1'b0, col_q} == (nblk_q - ONE_W));
  assign last_blk   = row_wrap & col_wrap;
  assign empty_tile = (params_q.x_rows == '0) | (params_q.y_columns == '0);

  z_tile_store_scheduler_addr_gen #(
    .BW           (BW),
    .DATA_SIZE    (DATA_SIZE),
    .Y_BLOCK_SIZE (Y_BLOCK_SIZE),
    .CNT_W        (CNT_W)
  ) u_addr_gen (
    .row          (row_q),
    .col_blk      (col_q),
    .base_address (params_q.base_address),
    .row_stride   (params_q.row_stride),
    .y_columns    (params_q.y_columns),
    .base_addr    (gen_base),
    .tot_len      (gen_len)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, credit bookkeeping, index advance and next registered outputs.
  always_comb begin
    state_d  = state_q;
    params_d = params_q;
    nblk_d   = nblk_q;
    row_d    = row_q;
    col_d    = col_q;
    cr_d     = cr_q;
    base_d   = base_q;
    len_d    = len_q;
    cfg_d    = cfg_q;
    ovf_d    = ovf_q;

    // A proceed and an acceptance in the same cycle cancel out.
    if (state_q != ST_IDLE) begin
      if (proceed_i && !accept) begin
        if (cr_q == CR_MAX) ovf_d = 1'b1;
        else                cr_d  = cr_q + CR_ONE;
      end else if (!proceed_i && accept) begin
        cr_d = cr_q - CR_ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_PREP;
          params_d = params_i;
          nblk_d   = ({1'b0, params_i.y_columns} + BLK_M1) >> Y_SH;
          row_d    = '0;
          col_d    = '0;
        end
      end
      ST_PREP: begin
        if (empty_tile) begin
          state_d = ST_DONE;
        end else begin
          base_d  = gen_base;
          len_d   = gen_len;
          cfg_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          if (last_blk) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PREP;
            if (!params_q.col_major) begin
              if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ONE;
              end else begin
                col_d = col_q + ONE;
              end
            end else begin
              if (row_wrap) begin
                row_d = '0;
                col_d = col_q + ONE;
              end else begin
                row_d = row_q + ONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cr_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_i) begin
      state_d  = ST_IDLE;
      params_d = '0;
      nblk_d   = '0;
      row_d    = '0;
      col_d    = '0;
      cr_d     = '0;
      base_d   = '0;
      len_d    = '0;
      cfg_d    = 1'b0;
      ovf_d    = 1'b0;
    end

    valid_d = (state_d == ST_ISSUE) && (cr_d != '0);
    busy_d  = (state_d == ST_PREP) || (state_d == ST_ISSUE);
    done_d  = (state_d == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      params_q <= '0;
      nblk_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cr_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      cfg_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      params_q <= params_d;
      nblk_q   <= nblk_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cr_q     <= cr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Assemble the streamer control word from the registered fields.
  always_comb begin
    store.ctrl           = '0;
    store.ctrl.req_start = valid_q;
    store.ctrl.base_addr = base_q;
    store.ctrl.tot_len   = len_q;
    store.ctrl.d0_len    = len_q;
    store.ctrl.d0_stride = cfg_q ? 32'(BW / 8) : 32'd0;
  end

  assign store.req_valid = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign row_o           = row_q;
  assign col_blk_o       = col_q;
  assign overflow_o      = ovf_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_z_tile_store_scheduler.sv
// Bench for z_tile_store_scheduler with Y_BLOCK_SIZE=8: directed scenarios
// followed by random tiles, checked against a block-list model and a
// credit model kept in the bench.
module tb_z_tile_store_scheduler;
  import z_tile_store_scheduler_pkg::*;

  localparam int YB    = 8;
  localparam int DEPTH = 4;
  localparam int W     = 160;
  localparam int CHW   = 260;
  typedef logic [CHW-1:0] chk_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          proceed = 1'b0;
  z_tile_param_t params = '0;
  logic          busy, done, ovf;
  logic [15:0]   row, col;
  z_state_e      state;

  z_tile_store_scheduler_if store_if ();

  z_tile_store_scheduler #(
    .BW           (128),
    .DATA_SIZE    (32),
    .Y_BLOCK_SIZE (YB),
    .CREDIT_DEPTH (DEPTH),
    .CNT_W        (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .start_i    (start),
    .params_i   (params),
    .proceed_i  (proceed),
    .store      (store_if),
    .busy_o     (busy),
    .done_o     (done),
    .row_o      (row),
    .col_blk_o  (col),
    .overflow_o (ovf),
    .state_o    (state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard and models
  logic [W-1:0]       exp_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 n_acc = 0;
  int                 n_done = 0;
  int                 done_mark = 0;
  int                 m_cred = 0;
  logic               m_ovf = 1'b0;
  logic               hold = 1'b0;
  logic               prev_done = 1'b0;
  logic               acc;
  hci_streamer_ctrl_t held;
  logic [W-1:0]       mon_e;

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected block list of a tile: nested loops over rows and column blocks.
  task automatic push_tile(input logic [31:0] base, input logic [31:0] stride,
                           input int x, input int y, input bit cm);
    int nblk, outer, inner, r, c, cols;
    logic [31:0] addr, len;
    if (x == 0 || y == 0) return;
    nblk  = (y + YB - 1) / YB;
    outer = cm ? nblk : x;
    inner = cm ? x : nblk;
    for (int a = 0; a < outer; a++) begin
      for (int b = 0; b < inner; b++) begin
        r    = cm ? b : a;
        c    = cm ? a : b;
        cols = y - c * YB;
        if (cols > YB) cols = YB;
        len  = 32'((cols * 32 + 127) / 128);
        addr = base + 32'(r) * stride + 32'(c * YB * 4);
        exp_q.push_back({addr, len, len, 32'd16, 16'(r), 16'(c)});
      end
    end
  endtask

  // Cycle monitor: credit/overflow model, hold stability, request scoreboard.
  always @(negedge clk) begin
    if (!rst_n || clear) begin
      m_cred    = 0;
      m_ovf     = 1'b0;
      hold      = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("overflow", chk_t'(ovf), chk_t'(m_ovf));
      if (store_if.req_valid) check("valid_needs_credit", chk_t'(m_cred > 0), chk_t'(1));
      if (hold) begin
        check("hold_valid", chk_t'(store_if.req_valid), chk_t'(1));
        check("hold_ctrl", chk_t'(store_if.ctrl), chk_t'(held));
      end
      if (done) begin
        n_done++;
        check("done_not_busy", chk_t'(busy), chk_t'(0));
        check("done_one_cycle", chk_t'(prev_done), chk_t'(0));
      end
      prev_done = done;
      acc = store_if.req_valid && store_if.req_ready;
      if (acc) begin
        n_acc++;
        check("sb_nonempty", chk_t'(exp_q.size() != 0), chk_t'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("store_req", chk_t'({store_if.ctrl.base_addr, store_if.ctrl.tot_len,
                                     store_if.ctrl.d0_len, store_if.ctrl.d0_stride, row, col}),
                chk_t'(mon_e));
        end
      end
      hold = store_if.req_valid && !store_if.req_ready;
      held = store_if.ctrl;
      if (busy || done) begin
        if (proceed && !acc) begin
          if (m_cred == DEPTH) m_ovf = 1'b1;
          else m_cred++;
        end else if (!proceed && acc) begin
          m_cred--;
        end
      end
      if (!busy) m_cred = 0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [31:0] base, input logic [31:0] stride,
                            input int x, input int y, input bit cm);
    params.base_address = base;
    params.row_stride   = stride;
    params.x_rows       = 16'(x);
    params.y_columns    = 16'(y);
    params.col_major    = cm;
    done_mark = n_done;
    push_tile(base, stride, x, y, cm);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_proceed(input int n);
    for (int i = 0; i < n; i++) begin
      proceed = 1'b1;
      step();
    end
    proceed = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (n_done == done_mark && k < budget) begin
      step();
      k++;
    end
    check(tag, chk_t'(n_done != done_mark), chk_t'(1));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (!store_if.req_valid && k < budget) begin
      step();
      k++;
    end
    check(tag, chk_t'(store_if.req_valid), chk_t'(1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int a0;
    int d0;
    int x, y;
    logic [31:0] base, stride;
    bit cm;

    // reset
    store_if.req_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_valid", chk_t'(store_if.req_valid), chk_t'(0));
    check("rst_busy", chk_t'(busy), chk_t'(0));
    check("rst_done", chk_t'(done), chk_t'(0));
    check("rst_ovf", chk_t'(ovf), chk_t'(0));
    check("rst_ctrl", chk_t'(store_if.ctrl), chk_t'(0));
    check("rst_idx", chk_t'({row, col}), chk_t'(0));
    check("rst_state", chk_t'(state), chk_t'(ST_IDLE));

    // base case, row-major
    store_if.req_ready = 1'b1;
    start_tile(32'h1000, 32'h28, 2, 10, 1'b0);
    pulse_proceed(4);
    wait_done(60, "base_done");
    step();
    check("base_busy_after", chk_t'(busy), chk_t'(0));
    check("base_sb_drained", chk_t'(exp_q.size()), chk_t'(0));

    // column-major order
    start_tile(32'h1000, 32'h28, 2, 10, 1'b1);
    pulse_proceed(4);
    wait_done(60, "colmaj_done");
    check("colmaj_sb_drained", chk_t'(exp_q.size()), chk_t'(0));

    // backpressure on the first request
    store_if.req_ready = 1'b0;
    start_tile(32'h1000, 32'h28, 2, 10, 1'b0);
    pulse_proceed(4);
    wait_valid(10, "bp_valid_up");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", chk_t'(store_if.req_valid), chk_t'(1));
      check("bp_addr_held", chk_t'(store_if.ctrl.base_addr), chk_t'(32'h1000));
      step();
    end
    a0 = n_acc;
    store_if.req_ready = 1'b1;
    step();
    check("bp_first_ready_accept", chk_t'(n_acc - a0), chk_t'(1));
    wait_done(60, "bp_done");

    // credit gating, then clear mid-tile
    start_tile(32'h1000, 32'h28, 2, 10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("gate_no_valid", chk_t'(store_if.req_valid), chk_t'(0));
      step();
    end
    a0 = n_acc;
    pulse_proceed(1);
    repeat (10) step();
    check("gate_one_req", chk_t'(n_acc - a0), chk_t'(1));
    check("gate_valid_low", chk_t'(store_if.req_valid), chk_t'(0));
    check("gate_busy", chk_t'(busy), chk_t'(1));
    d0 = n_done;
    do_clear();
    check("clr_state", chk_t'(state), chk_t'(ST_IDLE));
    check("clr_outputs", chk_t'({store_if.req_valid, busy, done, ovf, row, col}), chk_t'(0));
    check("clr_ctrl", chk_t'(store_if.ctrl), chk_t'(0));
    repeat (3) step();
    check("clr_no_done", chk_t'(n_done - d0), chk_t'(0));

    // saturation, then proceed coinciding with an acceptance
    store_if.req_ready = 1'b0;
    start_tile(32'h2000, 32'h40, 3, 16, 1'b0);
    pulse_proceed(5);
    step();
    check("sat_ovf", chk_t'(ovf), chk_t'(1));
    a0 = n_acc;
    store_if.req_ready = 1'b1;
    proceed = 1'b1;
    step();
    proceed = 1'b0;
    repeat (20) step();
    check("sat_accepts", chk_t'(n_acc - a0), chk_t'(5));
    check("sat_valid_low", chk_t'(store_if.req_valid), chk_t'(0));
    check("sat_busy", chk_t'(busy), chk_t'(1));
    check("sat_ovf_sticky", chk_t'(ovf), chk_t'(1));
    do_clear();
    check("sat_ovf_cleared", chk_t'(ovf), chk_t'(0));

    // empty tile: y_columns = 0
    start_tile(32'h3000, 32'h10, 2, 0, 1'b0);
    check("y0_prep_no_done", chk_t'(done), chk_t'(0));
    step();
    check("y0_done", chk_t'(done), chk_t'(1));
    check("y0_no_valid", chk_t'(store_if.req_valid), chk_t'(0));
    step();
    check("y0_done_pulse", chk_t'(done), chk_t'(0));
    check("y0_idle", chk_t'(busy), chk_t'(0));

    // random tiles with random proceed/ready traffic
    for (int t = 0; t < 8; t++) begin
      x      = $urandom_range(1, 3);
      y      = $urandom_range(1, 20);
      base   = $urandom;
      stride = 32'($urandom_range(0, 255) * 4);
      cm     = 1'($urandom_range(0, 1));
      proceed = 1'b0;
      store_if.req_ready = 1'b0;
      start_tile(base, stride, x, y, cm);
      for (int k = 0; k < 400 && n_done == done_mark; k++) begin
        proceed = 1'($urandom_range(0, 1));
        store_if.req_ready = 1'($urandom_range(0, 1));
        step();
      end
      proceed = 1'b0;
      store_if.req_ready = 1'b0;
      check("rnd_done", chk_t'(n_done != done_mark), chk_t'(1));
      step();
      check("rnd_sb_drained", chk_t'(exp_q.size()), chk_t'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z_tile_store_scheduler.md
Name: z_tile_store_scheduler

Overview:
Successor Z-store scheduler for the SpMM accelerator output path. It walks the full 2-D Z tile: X rows times Y column blocks, with a runtime row stride and a selectable traversal order. For each block it issues one hci_streamer_ctrl_t store request over a valid/ready handshake. Issue is gated by a credit counter that the compute engine fills via proceed pulses. It sits between the engine controller and the Z sink streamer.

Parameters:
BW, 128, memory bus width in bits (power of 2, >= DATA_SIZE)
DATA_SIZE, 32, Z element width in bits (8/16/32/64)
Y_BLOCK_SIZE, 4, Y columns per block (power of 2)
CREDIT_DEPTH, 4, maximum outstanding proceed credits
CNT_W, 16, width of row/column/block counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous clear to IDLE
start_i  in  1  begin a tile; params_i sampled this cycle
params_i  in  z_tile_param_t  base_address[31:0], row_stride[31:0] (bytes), x_rows[CNT_W-1:0], y_columns[CNT_W-1:0], col_major (1 = rows inner loop)
proceed_i  in  1  one block of Z ready in engine; +1 credit
ctrl_o  out  hci_streamer_ctrl_t  store configuration
req_valid_o  out  1  ctrl_o valid
req_ready_i  in  1  streamer accepts ctrl_o
busy_o  out  1  tile in progress
done_o  out  1  one-cycle pulse, tile finished
row_o  out  CNT_W  row index of the current request
col_blk_o  out  CNT_W  column-block index of the current request
overflow_o  out  1  sticky: proceed_i received with credits saturated

Behaviour:
- All outputs are registered. On reset or clear_i: state IDLE, all counters 0, credits 0, ctrl_o '0, req_valid_o/busy_o/done_o/overflow_o 0.
- Latched at start: nblk = ceil(y_columns / Y_BLOCK_SIZE), computed with a shift.
- FSM states: IDLE, PREP, ISSUE, DONE.
- IDLE -> PREP when start_i. Latch params, clear row/col_blk, set busy_o=1. start_i in any other state is ignored.
- PREP, one cycle:
  - If x_rows==0 or y_columns==0, go to DONE.
  - Otherwise compute ctrl_o for (row, col_blk), then go to ISSUE.
- ctrl_o fields:
  - cols = min(Y_BLOCK_SIZE, y_columns - col_blk*Y_BLOCK_SIZE)
  - base_addr = base_address + row*row_stride + col_blk*Y_BLOCK_SIZE*(DATA_SIZE/8), 32-bit, wraps modulo 2^32
  - tot_len = d0_len = ceil(cols*DATA_SIZE/BW)
  - d0_stride = BW/8
  - d1..d3 fields and dim_enable_1h all 0
  - req_start = req_valid_o
- ISSUE:
  - req_valid_o = (credits != 0).
  - ctrl_o, row_o and col_blk_o are held stable while req_valid_o && !req_ready_i.
  - On acceptance (valid && ready): credits -1. If this was the last block, go to DONE; otherwise advance the indices and go to PREP. Each request therefore takes at least 2 cycles.
- Advance rule:
  - row-major: col_blk++; when col_blk wraps to 0, row++.
  - col_major: row++; when row wraps to 0, col_blk++.
  - Last block is row==x_rows-1 and col_blk==nblk-1.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE. Leftover credits are cleared.
- Credits:
  - Count 0..CREDIT_DEPTH and are accepted in every state except IDLE.
  - If proceed_i and acceptance occur in the same cycle, the count is unchanged.
  - proceed_i at CREDIT_DEPTH without a simultaneous acceptance saturates the count and sets overflow_o; only reset or clear clears it.
- clear_i mid-tile aborts at once: req_valid_o drops next cycle and no done_o is produced.
- Arithmetic is CNT_W+1 bits internally. The partial-block subtraction never underflows because col_blk < nblk.

Decomposition:
- accelerator_package: z_tile_param_t, plus a function z_blk_len(cols, DATA_SIZE, BW) returning the ceil-div beat count.
- Sub-module z_tile_addr_gen (combinational/registered): takes row, col_blk and latched params, produces base_addr and tot_len. This keeps the FSM free of datapath logic.

Test Plan:
- Base case, defaults with Y_BLOCK_SIZE=8: base 0x1000, row_stride 0x28, x_rows=2, y_columns=10, row-major, ready=1, 4 proceeds.
  - Expect base_addr 0x1000 (tot_len 2), 0x1020 (1), 0x1028 (2), 0x1048 (1).
  - Expect a done_o pulse, then busy_o=0.
- col_major=1, same params -> order 0x1000, 0x1028, 0x1020, 0x1048; row_o sequence 0,1,0,1.
- Backpressure: req_ready_i low for 5 cycles on the first request -> ctrl_o stable, req_valid_o held; accepted on the first ready cycle.
- Credit gating: no proceed_i after start -> req_valid_o stays 0. One proceed_i -> exactly one request, then valid drops.
- Saturation: 5 proceed pulses in ISSUE with ready=0 and CREDIT_DEPTH=4 -> overflow_o=1 and stays 1. A proceed simultaneous with an acceptance keeps the count unchanged.
- Edge cases:
  - y_columns=0 -> done_o two cycles after start, no req_valid_o.
  - clear_i mid-tile -> IDLE, outputs '0, no done_o; a new start_i works.
